// File: rtl/serial_bus_arbiter_n.sv
// ============================================================================
// Module      : serial_bus_arbiter_n
// Description : N-master serial bus arbiter. Fixed-priority or round-robin
//               grant, single outstanding split-transaction parking for one
//               split-capable slave, and an optional grant hold timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bus_arbiter_n #(
    parameter int NUM_MASTERS    = 2,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         breq,
    output logic [NUM_MASTERS-1:0]         bgrant,
    output logic [NUM_MASTERS-1:0]         msplit,
    output logic [$clog2(NUM_MASTERS)-1:0] owner_id,
    output logic                           bus_busy,
    input  logic                           s_split_req,
    input  logic                           s_split_done,
    output logic                           s_split_grant,
    output logic                           timeout
);

    localparam int c_OW = $clog2(NUM_MASTERS);
    localparam int c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit c_TO_EN = (TIMEOUT_CYCLES > 0);
    localparam bit c_RR_EN = (RR_MODE != 0);
    localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_OW-1:0] c_LAST_IDX = c_OW'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] c_ONE = NUM_MASTERS'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0]  r_grant, w_grant_nxt;
    logic [NUM_MASTERS-1:0]  r_msplit, w_msplit_nxt;
    logic [c_OW-1:0]         r_owner, w_owner_nxt;
    logic                    r_split_grant, w_split_grant_nxt;
    logic                    r_timeout, w_timeout_nxt;
    logic [c_OW-1:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic                    r_pending, w_pending_nxt;
    logic                    r_done_seen, w_done_seen_nxt;
    logic [c_OW-1:0]         r_parked, w_parked_nxt;
    logic [NUM_MASTERS-1:0]  r_to_mask, w_to_mask_nxt;
    logic [c_CW-1:0]         r_count, w_count_nxt;

    logic [NUM_MASTERS-1:0]  w_parked_mask;
    logic [NUM_MASTERS-1:0]  w_eligible;
    logic [c_OW-1:0]         w_cand;
    logic [c_OW-1:0]         w_winner;
    logic                    w_found;
    logic [c_OW-1:0]         w_owner_inc;

    // Pick the winning eligible master: lowest index, or first at/after rr_ptr
    always_comb begin
        w_parked_mask = '0;
        if (r_pending) begin
            w_parked_mask[r_parked] = 1'b1;
        end
        w_eligible = breq & ~w_parked_mask & ~r_to_mask;
        w_cand     = '0;
        w_winner   = '0;
        w_found    = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (c_RR_EN) begin
                if (int'(r_rr_ptr) + k >= NUM_MASTERS) begin
                    w_cand = c_OW'(int'(r_rr_ptr) + k - NUM_MASTERS);
                end else begin
                    w_cand = c_OW'(int'(r_rr_ptr) + k);
                end
            end else begin
                w_cand = c_OW'(k);
            end
            if (!w_found && w_eligible[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
        w_owner_inc = (r_owner == c_LAST_IDX) ? '0 : r_owner + c_OW'(1);
    end

    // Next-state and output decode for the IDLE/BUSY arbitration FSM
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_msplit_nxt      = r_msplit;
        w_owner_nxt       = r_owner;
        w_split_grant_nxt = r_split_grant;
        w_timeout_nxt     = 1'b0;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_pending_nxt     = r_pending;
        w_done_seen_nxt   = r_done_seen;
        w_parked_nxt      = r_parked;
        // A timed-out master is re-admitted once it has dropped its request
        w_to_mask_nxt     = r_to_mask & breq;
        w_count_nxt       = r_count;

        if (r_pending && s_split_done) begin
            w_done_seen_nxt = 1'b1;
        end
        // Parked master abandoned its transaction: forget the split quietly
        if (r_pending && !breq[r_parked]) begin
            w_pending_nxt            = 1'b0;
            w_done_seen_nxt          = 1'b0;
            w_msplit_nxt[r_parked]   = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (r_pending && r_done_seen && breq[r_parked]) begin
                    // Split resume outranks any new request
                    w_grant_nxt            = c_ONE << r_parked;
                    w_owner_nxt            = r_parked;
                    w_msplit_nxt[r_parked] = 1'b0;
                    w_split_grant_nxt      = 1'b1;
                    w_pending_nxt          = 1'b0;
                    w_done_seen_nxt        = 1'b0;
                    w_count_nxt            = '0;
                    w_state_nxt            = S_BUSY;
                end else if (w_found) begin
                    w_grant_nxt       = c_ONE << w_winner;
                    w_owner_nxt       = w_winner;
                    w_split_grant_nxt = 1'b0;
                    w_count_nxt       = '0;
                    w_state_nxt       = S_BUSY;
                end
            end
            S_BUSY: begin
                if (s_split_req && !r_pending) begin
                    // Park the owner even if it released on this same cycle
                    w_grant_nxt           = '0;
                    w_msplit_nxt[r_owner] = 1'b1;
                    w_parked_nxt          = r_owner;
                    w_pending_nxt         = 1'b1;
                    w_done_seen_nxt       = 1'b0;
                    w_split_grant_nxt     = 1'b0;
                    w_state_nxt           = S_IDLE;
                end else if (c_TO_EN && (r_count == c_TO_LAST) && breq[r_owner]) begin
                    w_grant_nxt            = '0;
                    w_timeout_nxt          = 1'b1;
                    w_to_mask_nxt[r_owner] = 1'b1;
                    w_split_grant_nxt      = 1'b0;
                    if (c_RR_EN) begin
                        w_rr_ptr_nxt = w_owner_inc;
                    end
                    w_state_nxt = S_IDLE;
                end else if (!breq[r_owner]) begin
                    w_grant_nxt       = '0;
                    w_split_grant_nxt = 1'b0;
                    if (c_RR_EN) begin
                        w_rr_ptr_nxt = w_owner_inc;
                    end
                    w_state_nxt = S_IDLE;
                end else begin
                    w_count_nxt = r_count + c_CW'(1);
                end
            end
            default: begin
                w_grant_nxt       = '0;
                w_split_grant_nxt = 1'b0;
                w_state_nxt       = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_msplit      <= '0;
            r_owner       <= '0;
            r_split_grant <= 1'b0;
            r_timeout     <= 1'b0;
            r_rr_ptr      <= '0;
            r_pending     <= 1'b0;
            r_done_seen   <= 1'b0;
            r_parked      <= '0;
            r_to_mask     <= '0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_msplit      <= w_msplit_nxt;
            r_owner       <= w_owner_nxt;
            r_split_grant <= w_split_grant_nxt;
            r_timeout     <= w_timeout_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_pending     <= w_pending_nxt;
            r_done_seen   <= w_done_seen_nxt;
            r_parked      <= w_parked_nxt;
            r_to_mask     <= w_to_mask_nxt;
            r_count       <= w_count_nxt;
        end
    end

    assign bgrant        = r_grant;
    assign msplit        = r_msplit;
    assign owner_id      = r_owner;
    assign bus_busy      = |r_grant;
    assign s_split_grant = r_split_grant;
    assign timeout       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_serial_bus_arbiter_n.sv
// ============================================================================
// Module      : tb_serial_bus_arbiter_n
// Description : Self-checking bench for serial_bus_arbiter_n. A fixed-priority
//               instance runs a directed vector table; a round-robin instance
//               with an 8-cycle timeout runs hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_bus_arbiter_n;

    typedef struct packed {
        logic [2:0] b;
        logic       sr;
        logic       sd;
        logic [2:0] g;
        logic [2:0] ms;
        logic [1:0] own;
        logic       sg;
    } vec_t;

    logic       clk;
    logic       rstn;

    logic [2:0] f_breq, f_grant, f_msplit;
    logic [1:0] f_owner;
    logic       f_sreq, f_sdone, f_busy, f_sg, f_to;

    logic [2:0] r_breq, r_grant, r_msplit;
    logic [1:0] r_owner;
    logic       r_sreq, r_sdone, r_busy, r_sg, r_to;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    serial_bus_arbiter_n #(.NUM_MASTERS(3), .RR_MODE(0), .TIMEOUT_CYCLES(0)) u_fix (
        .clk(clk), .rstn(rstn), .breq(f_breq), .bgrant(f_grant), .msplit(f_msplit),
        .owner_id(f_owner), .bus_busy(f_busy), .s_split_req(f_sreq),
        .s_split_done(f_sdone), .s_split_grant(f_sg), .timeout(f_to)
    );

    serial_bus_arbiter_n #(.NUM_MASTERS(3), .RR_MODE(1), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .rstn(rstn), .breq(r_breq), .bgrant(r_grant), .msplit(r_msplit),
        .owner_id(r_owner), .bus_busy(r_busy), .s_split_req(r_sreq),
        .s_split_done(r_sdone), .s_split_grant(r_sg), .timeout(r_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [2:0] b, input logic sr, input logic sd,
                               input logic [2:0] g, input logic [2:0] ms,
                               input logic [1:0] own, input logic sg);
        vec_t t;
        t.b = b; t.sr = sr; t.sd = sd; t.g = g; t.ms = ms; t.own = own; t.sg = sg;
        return t;
    endfunction

    // Wait (bounded) for u_rr to grant someone; returns -1 if nobody is granted
    task automatic wait_grant(output int who);
        who = -1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (r_grant != 3'b000) begin
                for (int i = 0; i < 3; i++) if (r_grant[i]) who = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int who;
        int run;
        int order[4];
        logic [2:0] busy_seen;

        rstn = 1'b0;
        f_breq = '0; f_sreq = 1'b0; f_sdone = 1'b0;
        r_breq = '0; r_sreq = 1'b0; r_sdone = 1'b0;

        // Fixed-priority vectors: inputs for one cycle, expected outputs after that edge
        //                  breq    sr sd  grant   msplit  own  sg
        vecs.push_back(v(3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));
        vecs.push_back(v(3'b110, 0, 0, 3'b010, 3'b000, 2'd1, 0));
        vecs.push_back(v(3'b110, 0, 0, 3'b010, 3'b000, 2'd1, 0));
        vecs.push_back(v(3'b100, 0, 0, 3'b000, 3'b000, 2'd1, 0));
        vecs.push_back(v(3'b100, 0, 0, 3'b100, 3'b000, 2'd2, 0));
        vecs.push_back(v(3'b000, 0, 0, 3'b000, 3'b000, 2'd2, 0));
        vecs.push_back(v(3'b001, 0, 0, 3'b001, 3'b000, 2'd0, 0));
        vecs.push_back(v(3'b111, 1, 0, 3'b000, 3'b001, 2'd0, 0));
        vecs.push_back(v(3'b111, 0, 0, 3'b010, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b111, 0, 1, 3'b010, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b101, 0, 0, 3'b000, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b101, 0, 0, 3'b001, 3'b000, 2'd0, 1));
        vecs.push_back(v(3'b100, 0, 0, 3'b000, 3'b000, 2'd0, 0));
        vecs.push_back(v(3'b100, 0, 0, 3'b100, 3'b000, 2'd2, 0));
        vecs.push_back(v(3'b000, 0, 0, 3'b000, 3'b000, 2'd2, 0));
        vecs.push_back(v(3'b010, 0, 0, 3'b010, 3'b000, 2'd1, 0));
        vecs.push_back(v(3'b000, 1, 0, 3'b000, 3'b010, 2'd1, 0));
        vecs.push_back(v(3'b000, 0, 0, 3'b000, 3'b000, 2'd1, 0));
        vecs.push_back(v(3'b011, 0, 0, 3'b001, 3'b000, 2'd0, 0));
        vecs.push_back(v(3'b011, 1, 0, 3'b000, 3'b001, 2'd0, 0));
        vecs.push_back(v(3'b011, 0, 0, 3'b010, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b011, 1, 0, 3'b010, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b001, 0, 0, 3'b000, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b001, 0, 0, 3'b000, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b001, 0, 1, 3'b000, 3'b001, 2'd1, 0));
        vecs.push_back(v(3'b001, 0, 0, 3'b001, 3'b000, 2'd0, 1));
        vecs.push_back(v(3'b000, 0, 0, 3'b000, 3'b000, 2'd0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_fix", int'({f_grant, f_msplit, f_owner, f_busy, f_sg, f_to}), 0);
        check("reset_rr",  int'({r_grant, r_msplit, r_owner, r_busy, r_sg, r_to}), 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            f_breq  = vecs[i].b;
            f_sreq  = vecs[i].sr;
            f_sdone = vecs[i].sd;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  int'({f_grant, f_msplit, f_owner, f_busy, f_sg, f_to}),
                  int'({vecs[i].g, vecs[i].ms, vecs[i].own, |vecs[i].g, vecs[i].sg, 1'b0}));
        end
        @(negedge clk);
        f_breq = '0; f_sreq = 1'b0; f_sdone = 1'b0;

        // Round-robin order with all three requesting, each holding 4 cycles
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        r_breq = 3'b111;
        for (int n = 0; n < 4; n++) begin
            wait_grant(who);
            check($sformatf("rr_order%0d", n), who, order[n]);
            if (who < 0) who = 0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            r_breq = 3'b111 & ~(3'b001 << who);
            @(posedge clk); #1;
            check($sformatf("rr_release%0d", n), int'(r_grant), 0);
            @(negedge clk);
            r_breq = 3'b111;
        end

        // Reset while M1 owns: outputs clear immediately, M0 wins afterwards
        wait_grant(who);
        check("rr_m1_owner", who, 1);
        #3;
        rstn = 1'b0;
        #1;
        check("async_reset", int'({r_grant, r_msplit, r_owner, r_busy, r_sg, r_to}), 0);
        r_breq = 3'b011;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("reset_first_grant", int'(r_grant), 1);

        // Timeout: M0 holds its request; grant must last exactly 8 cycles
        run = 1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (r_grant == 3'b001) run++;
            else break;
        end
        check("to_hold_len", run, 8);
        check("to_pulse", int'({r_grant, r_to}), 1);
        @(posedge clk); #1;
        check("to_next_owner", int'({r_grant, r_to}), int'({3'b010, 1'b0}));
        @(negedge clk);
        r_breq = 3'b001;
        busy_seen = '0;
        @(posedge clk);
        for (int n = 0; n < 9; n++) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | r_grant;
        end
        check("to_masked", int'(busy_seen), 0);
        @(negedge clk);
        r_breq = 3'b000;
        @(negedge clk);
        r_breq = 3'b001;
        wait_grant(who);
        check("to_regrant", who, 0);
        @(negedge clk);
        r_breq = 3'b000;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
